// File: rtl/page_table_walker.sv
// rtl/page_table_walker.sv - two-level (10/10/12) page-table walker behind the TLB miss port.
// Optional one-entry cache of the last non-leaf L1 PTE when PTW_L1_CACHE_EN is defined.
module page_table_walker #(
  parameter int PAGE_OFFSET_BITS = 12,
  parameter int VPN_IDX_BITS     = 10,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] vaddr_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] pte_o,
  output logic        fault_o,
  input  logic [19:0] satp_ppn_i,
  input  logic        flush_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_resp_valid_i,
  input  logic [31:0] mem_rdata_i
);

  if (PAGE_OFFSET_BITS + 2 * VPN_IDX_BITS != 32 || VPN_IDX_BITS != 10) begin : g_bad_geometry
    $error("page_table_walker only supports the 10/10/12 Sv32-style split");
  end

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_L1_REQ, S_L1_WAIT, S_L0_REQ, S_L0_WAIT, S_RESP
  } state_t;

  state_t state_q, state_d;
  logic [19:0] va_q, va_d;      // vaddr[31:12]; the page offset is never needed
  logic [19:0] root_q, root_d;
  logic [19:0] tbl_q, tbl_d;
  logic [31:0] pte_q, pte_d;
  logic        fault_q, fault_d;
  logic [WD_W-1:0] wd_q;
  logic        in_wait, timeout, fill, cache_hit;
  logic [19:0] cache_ppn;

  logic pte_v, pte_l, pte_wr;
  assign pte_v  = mem_rdata_i[2];
  assign pte_l  = mem_rdata_i[3];
  assign pte_wr = |mem_rdata_i[1:0];

  assign in_wait = (state_q == S_L1_WAIT) || (state_q == S_L0_WAIT);
  assign timeout = (TIMEOUT_CYCLES != 0) && (wd_q == WD_MAX);

  always_comb begin
    state_d = state_q;
    va_d    = va_q;
    root_d  = root_q;
    tbl_d   = tbl_q;
    pte_d   = pte_q;
    fault_d = fault_q;
    fill    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          va_d    = vaddr_i[31:12];
          root_d  = satp_ppn_i;
          pte_d   = '0;
          fault_d = 1'b0;
          if (cache_hit) begin
            tbl_d   = cache_ppn;
            state_d = S_L0_REQ;
          end else begin
            state_d = S_L1_REQ;
          end
        end
      end
      S_L1_REQ: if (mem_req_ready_i) state_d = S_L1_WAIT;
      S_L1_WAIT: begin
        if (mem_resp_valid_i) begin
          if (pte_v && !pte_l) begin
            tbl_d   = mem_rdata_i[31:12];
            fill    = 1'b1;
            state_d = S_L0_REQ;
          end else begin
            // Superpage must be 4 MiB aligned: low ten PPN bits come from the vaddr.
            if (pte_v && pte_wr && (mem_rdata_i[21:12] == 10'd0)) begin
              pte_d = {mem_rdata_i[31:22], va_q[9:0], 10'd0, mem_rdata_i[1:0]};
            end else begin
              fault_d = 1'b1;
            end
            state_d = S_RESP;
          end
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = S_RESP;
        end
      end
      S_L0_REQ: if (mem_req_ready_i) state_d = S_L0_WAIT;
      S_L0_WAIT: begin
        if (mem_resp_valid_i) begin
          if (pte_v && pte_l && pte_wr) begin
            pte_d = {mem_rdata_i[31:12], 10'd0, mem_rdata_i[1:0]};
          end else begin
            fault_d = 1'b1;
          end
          state_d = S_RESP;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: if (resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      va_q    <= '0;
      root_q  <= '0;
      tbl_q   <= '0;
      pte_q   <= '0;
      fault_q <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      va_q    <= va_d;
      root_q  <= root_d;
      tbl_q   <= tbl_d;
      pte_q   <= pte_d;
      fault_q <= fault_d;
      wd_q    <= (in_wait && state_d == state_q) ? wd_q + WD_W'(1) : '0;
    end
  end

  assign req_ready_o     = (state_q == S_IDLE);
  assign mem_req_valid_o = (state_q == S_L1_REQ) || (state_q == S_L0_REQ);
  assign resp_valid_o    = (state_q == S_RESP);
  assign pte_o           = (state_q == S_RESP) ? pte_q : 32'd0;
  assign fault_o         = (state_q == S_RESP) && fault_q;

  always_comb begin
    mem_addr_o = 32'd0;
    if (state_q == S_L1_REQ) mem_addr_o = {root_q, 12'd0} + {20'd0, va_q[19:10], 2'b00};
    if (state_q == S_L0_REQ) mem_addr_o = {tbl_q, 12'd0} + {20'd0, va_q[9:0], 2'b00};
  end

`ifdef PTW_L1_CACHE_EN
  logic        c_valid, no_fill_q;
  logic [9:0]  c_tag;
  logic [19:0] c_root, c_ppn;

  assign cache_hit = c_valid && (c_tag == vaddr_i[31:22]) && (c_root == satp_ppn_i);
  assign cache_ppn = c_ppn;

  // A flush seen at any point of a walk keeps that walk from refilling the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid   <= 1'b0;
      no_fill_q <= 1'b0;
      c_tag     <= '0;
      c_root    <= '0;
      c_ppn     <= '0;
    end else begin
      if (state_q == S_IDLE && req_valid_i) no_fill_q <= flush_i;
      else if (flush_i)                     no_fill_q <= 1'b1;
      if (flush_i) begin
        c_valid <= 1'b0;
      end else if (fill && !no_fill_q) begin
        c_valid <= 1'b1;
        c_tag   <= va_q[19:10];
        c_root  <= root_q;
        c_ppn   <= mem_rdata_i[31:12];
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_ppn = '0;
  logic unused_cache;
  assign unused_cache = flush_i ^ fill;
`endif

  logic unused_rdata;
  assign unused_rdata = ^mem_rdata_i[11:4];

endmodule

// File: tb/tb_page_table_walker.sv
// tb/tb_page_table_walker.sv - self-checking bench for page_table_walker.
// Table vectors, hand-written stall/timeout/reset/cache sequences, randomized walks against a reference walk model.
module tb_page_table_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, resp_valid_o, resp_ready_i, fault_o;
  logic [31:0] vaddr_i, pte_o, mem_addr_o, mem_rdata_i;
  logic [19:0] satp_ppn_i;
  logic        flush_i, mem_req_valid_o, mem_req_ready_i, mem_resp_valid_i;

  page_table_walker #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .vaddr_i(vaddr_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .pte_o(pte_o), .fault_o(fault_o),
    .satp_ppn_i(satp_ppn_i), .flush_i(flush_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

`ifdef PTW_L1_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] req_log[$];
  logic [31:0] exp_addrs[$];
  bit          pend = 0, mem_mute = 0, ready_rand = 0, delay_rand = 0;
  int          pend_cnt = 0, resp_delay = 0;
  logic [31:0] pend_addr;

  bit          c_valid = 0;
  logic [9:0]  c_tag;
  logic [19:0] c_root, c_ppn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: record handshakes before the edge, then play the memory side after it.
  task automatic tick();
    bit hs;
    logic [31:0] a;
    hs = mem_req_valid_o && mem_req_ready_i;
    a  = mem_addr_o;
    @(posedge clk);
    #1;
    mem_resp_valid_i = 1'b0;
    mem_rdata_i      = $urandom;
    if (hs) begin
      req_log.push_back(a);
      if (!mem_mute) begin
        pend = 1; pend_cnt = resp_delay; pend_addr = a;
      end
    end
    if (pend) begin
      if (pend_cnt == 0) begin
        pend = 0;
        mem_resp_valid_i = 1'b1;
        mem_rdata_i = mem.exists(pend_addr) ? mem[pend_addr] : 32'd0;
      end else begin
        pend_cnt--;
      end
    end
    if (ready_rand) mem_req_ready_i = ($urandom_range(0, 2) != 0);
    if (delay_rand) resp_delay = $urandom_range(0, 3);
  endtask

  task automatic flush_pulse();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic do_walk(input logic [31:0] va, input logic [19:0] sp, input int hold,
                         output logic [31:0] p_out, output logic f_out, output int lat);
    int guard;
    req_log.delete();
    vaddr_i = va; satp_ppn_i = sp; req_valid_i = 1'b1;
    guard = 0;
    while (!req_ready_o && guard < 50) begin tick(); guard++; end
    tick();
    req_valid_i = 1'b0; vaddr_i = $urandom; satp_ppn_i = 20'($urandom);
    lat = 0;
    while (!resp_valid_o && lat < 100) begin tick(); lat++; end
    chk("walk_completes", resp_valid_o, 1'b1);
    p_out = pte_o; f_out = fault_o;
    repeat (hold) tick();
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_pte();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return r & ~32'h4;
      1, 2:    return {12'h002, 8'($urandom_range(0, 3)), r[11:4], 4'b0100};
      3:       return {r[31:22], 10'h0, r[11:4], 2'b11, r[1:0]};
      4:       return {r[31:4], 2'b11, r[1:0]};
      default: return {r[31:4], 2'b01, r[1:0]};
    endcase
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = rand_pte();
    return mem[a];
  endfunction

  // Reference walk: what a two-level translation should yield and which PTE words it must read.
  task automatic model_walk(input logic [31:0] va, input logic [19:0] sp,
                            output logic [31:0] pte, output bit flt);
    logic [31:0] a, d;
    logic [19:0] tbl;
    exp_addrs.delete();
    pte = 32'd0; flt = 1'b1;
    if (CACHE_ON && c_valid && c_tag == va[31:22] && c_root == sp) begin
      tbl = c_ppn;
    end else begin
      a = {sp, 12'h000} + 32'(va[31:22]) * 4;
      d = rd(a);
      exp_addrs.push_back(a);
      if (!d[2]) return;
      if (d[3]) begin
        if (d[21:12] != 10'd0 || d[1:0] == 2'b00) return;
        pte = {d[31:22], va[21:12], 10'h000, d[1:0]};
        flt = 1'b0;
        return;
      end
      tbl = d[31:12];
      if (CACHE_ON) begin c_valid = 1; c_tag = va[31:22]; c_root = sp; c_ppn = tbl; end
    end
    a = {tbl, 12'h000} + 32'(va[21:12]) * 4;
    d = rd(a);
    exp_addrs.push_back(a);
    if (d[2] && d[3] && d[1:0] != 2'b00) begin
      pte = {d[31:12], 10'h000, d[1:0]};
      flt = 1'b0;
    end
  endtask

  typedef struct {
    logic [31:0] va;
    logic [19:0] satp;
    logic [31:0] l1_addr, l1_data, l0_addr, l0_data, pte;
    bit          flt;
    int          reads;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench watchdog");
  end

  initial begin
    logic [31:0] p, ep, a0;
    logic        f;
    bit          ef, bad;
    int          lat, n;
    logic [31:0] va;
    logic [19:0] sp;

    vecs[0]  = '{32'h12345678, 20'h00010, 32'h00010120, 32'h00020005, 32'h00020D14, 32'hABCDE00F, 32'hABCDE003, 1'b0, 2, 4};
    vecs[1]  = '{32'h12345678, 20'h00010, 32'h00010120, 32'h8040000F, 32'h00020D14, 32'h00000000, 32'h80745003, 1'b0, 1, 2};
    vecs[2]  = '{32'h12345678, 20'h00010, 32'h00010120, 32'h8040100F, 32'h00020D14, 32'h00000000, 32'h00000000, 1'b1, 1, 2};
    vecs[3]  = '{32'h12345678, 20'h00010, 32'h00010120, 32'h00000000, 32'h00020D14, 32'h00000000, 32'h00000000, 1'b1, 1, 2};
    vecs[4]  = '{32'h12345678, 20'h00010, 32'h00010120, 32'h00020005, 32'h00020D14, 32'h00030005, 32'h00000000, 1'b1, 2, 4};
    vecs[5]  = '{32'h12345678, 20'h00010, 32'h00010120, 32'h0000000C, 32'h00020D14, 32'h00000000, 32'h00000000, 1'b1, 1, 2};
    vecs[6]  = '{32'h12345678, 20'h00010, 32'h00010120, 32'h00020005, 32'h00020D14, 32'hABCDE00C, 32'h00000000, 1'b1, 2, 4};
    vecs[7]  = '{32'h12345678, 20'h00010, 32'h00010120, 32'h00020005, 32'h00020D14, 32'h1234500E, 32'h12345002, 1'b0, 2, 4};
    vecs[8]  = '{32'h12345678, 20'h00010, 32'h00010120, 32'hC0000009, 32'h00020D14, 32'h00000000, 32'h00000000, 1'b1, 1, 2};
    vecs[9]  = '{32'hFFFFFFFF, 20'hFFFFF, 32'hFFFFFFFC, 32'h00001005, 32'h00001FFC, 32'hFFFFF00D, 32'hFFFFF001, 1'b0, 2, 4};
    vecs[10] = '{32'hFFFFFFFF, 20'hFFFFF, 32'hFFFFFFFC, 32'hFFC0000F, 32'h00001FFC, 32'h00000000, 32'hFFFFF003, 1'b0, 1, 2};

    rst = 1'b1; req_valid_i = 0; vaddr_i = 0; resp_ready_i = 0; satp_ppn_i = 0; flush_i = 0;
    mem_req_ready_i = 1; mem_resp_valid_i = 0; mem_rdata_i = 0;
    repeat (3) tick();
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_resp_valid", resp_valid_o, 1'b0);
    chk("rst_mem_req_valid", mem_req_valid_o, 1'b0);
    chk("rst_pte", pte_o, 32'h0);
    chk("rst_fault", fault_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      mem.delete();
      mem[vecs[i].l1_addr] = vecs[i].l1_data;
      mem[vecs[i].l0_addr] = vecs[i].l0_data;
      flush_pulse();
      do_walk(vecs[i].va, vecs[i].satp, 0, p, f, lat);
      chk($sformatf("vec%0d_pte", i), p, vecs[i].pte);
      chk($sformatf("vec%0d_fault", i), f, vecs[i].flt);
      chk($sformatf("vec%0d_reads", i), req_log.size(), vecs[i].reads);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      a0 = (req_log.size() > 0) ? req_log[0] : 32'hDEADBEEF;
      chk($sformatf("vec%0d_l1_addr", i), a0, vecs[i].l1_addr);
      if (req_log.size() > 1) chk($sformatf("vec%0d_l0_addr", i), req_log[1], vecs[i].l0_addr);
    end

    // Response backpressure: result held, new requests ignored.
    flush_pulse(); mem.delete(); mem[32'h00010120] = 32'h8040000F;
    req_log.delete();
    vaddr_i = 32'h12345678; satp_ppn_i = 20'h00010; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    n = 0;
    while (!resp_valid_o && n < 20) begin tick(); n++; end
    vaddr_i = 32'h00400000; req_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("hold_resp_valid", resp_valid_o, 1'b1);
      chk("hold_pte", pte_o, 32'h80745003);
      chk("hold_req_ready", req_ready_o, 1'b0);
      tick();
    end
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0; req_valid_i = 1'b0;
    chk("after_hs_req_ready", req_ready_o, 1'b1);
    chk("after_hs_resp_valid", resp_valid_o, 1'b0);
    chk("hold_no_new_read", req_log.size(), 1);
    chk("after_hs_mem_idle", mem_req_valid_o, 1'b0);

    // Memory request stall, then no response at all: watchdog fault.
    flush_pulse(); mem.delete(); mem[32'h00010120] = 32'h00020005;
    mem_mute = 1;
    vaddr_i = 32'h12345678; satp_ppn_i = 20'h00010; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0; mem_req_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_req_valid", mem_req_valid_o, 1'b1);
      chk("stall_addr", mem_addr_o, 32'h00010120);
    end
    mem_req_ready_i = 1'b1;
    tick();
    n = 0;
    while (!resp_valid_o && n < 40) begin tick(); n++; end
    chk("timeout_wait_cycles", n, 8);
    chk("timeout_fault", fault_o, 1'b1);
    chk("timeout_pte", pte_o, 32'h0);
    resp_ready_i = 1'b1; tick(); resp_ready_i = 1'b0;
    mem_mute = 0;

    // Reset while waiting on the L0 read; the late response must be dropped.
    flush_pulse(); mem.delete();
    mem[32'h00010120] = 32'h00020005; mem[32'h00020D14] = 32'hABCDE00F;
    resp_delay = 0;
    vaddr_i = 32'h12345678; satp_ppn_i = 20'h00010; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    tick();
    tick();
    resp_delay = 3;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midwalk_rst_req_ready", req_ready_o, 1'b1);
    chk("midwalk_rst_resp_valid", resp_valid_o, 1'b0);
    bad = 0;
    repeat (6) begin
      tick();
      if (resp_valid_o || mem_req_valid_o) bad = 1;
    end
    chk("stale_resp_ignored", bad, 1'b0);
    resp_delay = 0;

`ifdef PTW_L1_CACHE_EN
    flush_pulse(); mem.delete();
    mem[32'h00010120] = 32'h00020005; mem[32'h00020D14] = 32'hABCDE00F;
    do_walk(32'h12345678, 20'h00010, 0, p, f, lat);
    chk("cache_fill_lat", lat, 4);
    do_walk(32'h12345ABC, 20'h00010, 0, p, f, lat);
    chk("cache_hit_pte", p, 32'hABCDE003);
    chk("cache_hit_lat", lat, 2);
    chk("cache_hit_reads", req_log.size(), 1);
    a0 = (req_log.size() > 0) ? req_log[0] : 32'hDEADBEEF;
    chk("cache_hit_addr", a0, 32'h00020D14);
    flush_pulse();
    do_walk(32'h12345ABC, 20'h00010, 0, p, f, lat);
    chk("cache_flushed_lat", lat, 4);
    chk("cache_flushed_reads", req_log.size(), 2);
`endif

    // Randomized walks against the reference model.
    mem.delete(); flush_pulse(); c_valid = 0;
    ready_rand = 1; delay_rand = 1;
    for (int it = 0; it < 80; it++) begin
      va = {10'h048 + 10'($urandom_range(0, 3)), 10'($urandom), 12'($urandom)};
      sp = ($urandom_range(0, 1) != 0) ? 20'h00010 : 20'h00011;
      if ($urandom_range(0, 7) == 0) begin flush_pulse(); c_valid = 0; end
      model_walk(va, sp, ep, ef);
      do_walk(va, sp, $urandom_range(0, 3), p, f, lat);
      chk($sformatf("rnd%0d_pte", it), p, ep);
      chk($sformatf("rnd%0d_fault", it), f, ef);
      chk($sformatf("rnd%0d_reads", it), req_log.size(), exp_addrs.size());
      bad = 0;
      for (int k = 0; k < req_log.size() && k < exp_addrs.size(); k++)
        if (req_log[k] !== exp_addrs[k]) bad = 1;
      chk($sformatf("rnd%0d_addr_seq", it), bad, 1'b0);
    end
    ready_rand = 0; delay_rand = 0; mem_req_ready_i = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
